// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared types and constants for the data-cache refill controller.
// Line geometry and refill FSM state encoding.
package dcache_refill_ctrl_pkg;

    localparam int LINE_WORDS  = 4;
    localparam int OFFSET_BITS = 4;
    localparam int WORD_BITS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WBACK,
        ST_FILL,
        ST_UPDATE
    } state_t;

    // One-hot column select for a word within the line.
    function automatic logic [LINE_WORDS-1:0] word_onehot(input logic [1:0] w);
        return 4'b0001 << w;
    endfunction

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: writes back a dirty victim line word by word,
// refills the missing line into the data columns, then installs the tag.
module dcache_refill_ctrl
    import dcache_refill_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_miss,
    input  logic [31:0]           i_miss_addr,
    input  logic                  i_victim_dirty,
    input  logic [TAG_BITS-1:0]   i_victim_tag,
    input  logic [127:0]          i_victim_data,
    output logic                  o_busy,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [31:0]           o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata,
    output logic [3:0]            o_col_we,
    output logic [INDEX_BITS-1:0] o_col_index,
    output logic [31:0]           o_col_wdata,
    output logic                  o_tag_we,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic                  o_refill_done
);

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            wcnt_q;
    logic [1:0]            wcnt_d;
    logic [TAG_BITS-1:0]   miss_tag_q;
    logic [TAG_BITS-1:0]   victim_tag_q;
    logic [INDEX_BITS-1:0] index_q;
    logic [WORD_BITS-1:0]  victim_q [LINE_WORDS];
    logic [WORD_BITS-1:0]  rdata_q;
    logic [3:0]            col_we_q;
    logic                  accept;
    logic                  fill_ack;
    logic                  unused_offset;

    // The byte offset inside the line never matters: refills are whole lines.
    assign unused_offset = ^i_miss_addr[OFFSET_BITS-1:0];

    assign accept   = (state_q == ST_IDLE) && i_miss;
    assign fill_ack = (state_q == ST_FILL) && i_mem_ack;

    // State and word counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Capture the miss context and victim line when a miss is accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miss_tag_q   <= '0;
            victim_tag_q <= '0;
            index_q      <= '0;
            for (int w = 0; w < LINE_WORDS; w++) begin
                victim_q[w] <= '0;
            end
        end else if (accept) begin
            miss_tag_q   <= i_miss_addr[31 -: TAG_BITS];
            victim_tag_q <= i_victim_tag;
            index_q      <= i_miss_addr[OFFSET_BITS +: INDEX_BITS];
            for (int w = 0; w < LINE_WORDS; w++) begin
                victim_q[w] <= i_victim_data[WORD_BITS*w +: WORD_BITS];
            end
        end
    end

    // Register each fill word and strobe its column one cycle after the ack.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q  <= '0;
            col_we_q <= 4'b0000;
        end else begin
            col_we_q <= fill_ack ? word_onehot(wcnt_q) : 4'b0000;
            if (fill_ack) begin
                rdata_q <= i_mem_rdata;
            end
        end
    end

    // Next-state logic and memory/tag request outputs.
    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        o_tag_we      = 1'b0;
        o_refill_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_miss) begin
                    state_d = i_victim_dirty ? ST_WBACK : ST_FILL;
                    wcnt_d  = 2'd0;
                end
            end
            ST_WBACK: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {victim_tag_q, index_q, wcnt_q, 2'b00};
                o_mem_wdata = victim_q[wcnt_q];
                if (i_mem_ack) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {miss_tag_q, index_q, wcnt_q, 2'b00};
                if (i_mem_ack) begin
                    wcnt_d = wcnt_q + 2'd1;
                    if (wcnt_q == 2'd3) begin
                        state_d = ST_UPDATE;
                    end
                end
            end
            ST_UPDATE: begin
                o_tag_we      = 1'b1;
                o_refill_done = 1'b1;
                wcnt_d        = 2'd0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = 2'd0;
            end
        endcase
    end

    assign o_busy      = (state_q != ST_IDLE);
    assign o_col_we    = col_we_q;
    assign o_col_index = index_q;
    assign o_col_wdata = rdata_q;
    assign o_tag       = miss_tag_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: directed table, reset and
// handshake corner cases, and randomized refills against a line-level model.
module tb_dcache_refill_ctrl;

    import dcache_refill_ctrl_pkg::*;

    localparam int IB   = 3;
    localparam int TAGW = 32 - IB - 4;

    logic            clk;
    logic            nrst;
    logic            i_miss;
    logic [31:0]     i_miss_addr;
    logic            i_victim_dirty;
    logic [TAGW-1:0] i_victim_tag;
    logic [127:0]    i_victim_data;
    logic            o_busy;
    logic            o_mem_req;
    logic            o_mem_we;
    logic [31:0]     o_mem_addr;
    logic [31:0]     o_mem_wdata;
    logic            i_mem_ack;
    logic [31:0]     i_mem_rdata;
    logic [3:0]      o_col_we;
    logic [IB-1:0]   o_col_index;
    logic [31:0]     o_col_wdata;
    logic            o_tag_we;
    logic [TAGW-1:0] o_tag;
    logic            o_refill_done;

    dcache_refill_ctrl #(
        .INDEX_BITS(IB),
        .TAG_BITS  (TAGW)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .i_miss        (i_miss),
        .i_miss_addr   (i_miss_addr),
        .i_victim_dirty(i_victim_dirty),
        .i_victim_tag  (i_victim_tag),
        .i_victim_data (i_victim_data),
        .o_busy        (o_busy),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_col_we      (o_col_we),
        .o_col_index   (o_col_index),
        .o_col_wdata   (o_col_wdata),
        .o_tag_we      (o_tag_we),
        .o_tag         (o_tag),
        .o_refill_done (o_refill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int delay   = 0;
    int wait_cnt = 0;
    bit spur    = 1'b0;
    bit pend    = 1'b0;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwe;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];
    logic [3:0]  col_we_log [$];
    logic [31:0] col_data_q [$];
    logic [IB-1:0] col_idx_q [$];
    int          col_cyc_q [$];
    int          tag_cnt;
    logic [TAGW-1:0] tag_val;
    bit          done_seen;
    int          done_cyc;

    typedef struct {
        logic [31:0]     addr;
        bit              dirty;
        logic [TAGW-1:0] vtag;
        int              d;
        logic [IB-1:0]   idx;
        logic [TAGW-1:0] tag;
        logic [31:0]     rd0;
        logic [31:0]     wr0;
        int              cycles;
    } vec_t;

    vec_t tbl [5];

    // Backing memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        col_we_log.delete();
        col_data_q.delete();
        col_idx_q.delete();
        col_cyc_q.delete();
        tag_cnt   = 0;
        tag_val   = '0;
        done_seen = 1'b0;
        done_cyc  = 0;
    endtask

    // One clock: log the handshake closing at this edge, sample outputs
    // after the edge, check request stability, then drive the memory reply.
    task automatic step();
        if (i_mem_ack && o_mem_req) begin
            if (o_mem_we) begin
                wr_addr_q.push_back(o_mem_addr);
                wr_data_q.push_back(o_mem_wdata);
            end else begin
                rd_addr_q.push_back(o_mem_addr);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (o_col_we != 4'b0000) begin
            col_we_log.push_back(o_col_we);
            col_data_q.push_back(o_col_wdata);
            col_idx_q.push_back(o_col_index);
            col_cyc_q.push_back(cyc);
        end
        if (o_tag_we) begin
            tag_cnt++;
            tag_val = o_tag;
        end
        if (o_refill_done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (pend) begin
            chk("req_held", {31'd0, o_mem_req}, 32'd1);
            chk("req_addr_stable", o_mem_addr, paddr);
            chk("req_wdata_stable", o_mem_wdata, pwdata);
            chk("req_we_stable", {31'd0, o_mem_we}, {31'd0, pwe});
        end
        if (o_mem_req) begin
            if (wait_cnt >= delay) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = memfn(o_mem_addr);
                wait_cnt    = 0;
            end else begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            i_mem_ack   = spur;
            i_mem_rdata = $urandom;
        end
        pend   = o_mem_req && !i_mem_ack;
        paddr  = o_mem_addr;
        pwdata = o_mem_wdata;
        pwe    = o_mem_we;
    endtask

    // Run one refill to completion and check it against the line-level model.
    task automatic do_refill(input logic [31:0] addr, input bit dirty,
                             input logic [TAGW-1:0] vtag,
                             input logic [127:0] vdata, input int d,
                             input bit noisy, output int got_cycles,
                             output logic [31:0] got_rd0,
                             output logic [31:0] got_wr0);
        int a;
        int nw;
        int per;
        logic [IB-1:0]   e_idx;
        logic [TAGW-1:0] e_tag;
        logic [31:0]     base_rd;
        logic [31:0]     base_wr;
        e_idx   = addr[6:4];
        e_tag   = TAGW'(addr >> 7);
        base_rd = addr & 32'hFFFF_FFF0;
        base_wr = {vtag, e_idx, 4'b0000};
        nw      = dirty ? 4 : 0;
        per     = d + 1;
        clear_log();
        delay          = d;
        wait_cnt       = 0;
        i_miss_addr    = addr;
        i_victim_dirty = dirty;
        i_victim_tag   = vtag;
        i_victim_data  = vdata;
        i_miss         = 1'b1;
        step();
        a = cyc;
        chk("first_req", {31'd0, o_mem_req}, 32'd1);
        chk("busy_on_accept", {31'd0, o_busy}, 32'd1);
        chk("col_index", {29'd0, o_col_index}, {29'd0, e_idx});
        i_miss = 1'b0;
        for (int n = 0; n < 300 && !done_seen; n++) begin
            if (noisy) begin
                i_miss         = 1'($urandom);
                i_miss_addr    = $urandom;
                i_victim_dirty = 1'($urandom);
                i_victim_tag   = TAGW'($urandom);
                i_victim_data  = {$urandom, $urandom, $urandom, $urandom};
                spur           = 1'($urandom);
            end
            step();
        end
        i_miss = 1'b0;
        spur   = 1'b0;
        chk("done_seen", {31'd0, done_seen}, 32'd1);
        step();
        chk("idle_after_done", {31'd0, o_busy}, 32'd0);
        got_cycles = done_cyc - a + 1;
        chk("cycles", got_cycles, (nw + 4) * per + 1);
        chk("n_writes", wr_addr_q.size(), nw);
        for (int w = 0; w < nw && w < wr_addr_q.size(); w++) begin
            chk("wr_addr", wr_addr_q[w], base_wr + 32'(4 * w));
            chk("wr_data", wr_data_q[w], vdata[32*w +: 32]);
        end
        chk("n_reads", rd_addr_q.size(), 4);
        for (int w = 0; w < 4 && w < rd_addr_q.size(); w++) begin
            chk("rd_addr", rd_addr_q[w], base_rd + 32'(4 * w));
        end
        chk("n_col", col_we_log.size(), 4);
        for (int w = 0; w < 4 && w < col_we_log.size(); w++) begin
            chk("col_we", {28'd0, col_we_log[w]}, 32'd1 << w);
            chk("col_data", col_data_q[w], memfn(base_rd + 32'(4 * w)));
            chk("col_idx", {29'd0, col_idx_q[w]}, {29'd0, e_idx});
            chk("col_cycle", col_cyc_q[w], a + nw * per + (w + 1) * per);
        end
        chk("tag_we_cnt", tag_cnt, 1);
        chk("tag", {7'd0, tag_val}, {7'd0, e_tag});
        got_rd0 = (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hDEAD_DEAD;
        got_wr0 = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'h0;
    endtask

    initial begin
        int          gc;
        logic [31:0] gr;
        logic [31:0] gw;
        logic [127:0] vd;

        vd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        tbl[0] = '{32'h0000_1234, 1'b0, 25'h0, 0, 3'd3, 25'h24,
                   32'h0000_1230, 32'h0, 5};
        tbl[1] = '{32'h0000_12B8, 1'b1, 25'h5, 0, 3'd3, 25'h25,
                   32'h0000_12B0, 32'h0000_02B0, 9};
        tbl[2] = '{32'h8000_00F0, 1'b0, 25'h0, 3, 3'd7, 25'h100_0001,
                   32'h8000_00F0, 32'h0, 17};
        tbl[3] = '{32'hFFFF_FFFC, 1'b1, 25'h1FF_FFFF, 1, 3'd7, 25'h1FF_FFFF,
                   32'hFFFF_FFF0, 32'hFFFF_FFF0, 17};
        tbl[4] = '{32'h0000_0000, 1'b1, 25'h0AB_CDE, 2, 3'd0, 25'h0,
                   32'h0000_0000, 32'h055E_6F00, 25};

        nrst           = 1'b0;
        i_miss         = 1'b0;
        i_miss_addr    = '0;
        i_victim_dirty = 1'b0;
        i_victim_tag   = '0;
        i_victim_data  = '0;
        i_mem_ack      = 1'b0;
        i_mem_rdata    = '0;
        clear_log();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_we", {31'd0, o_mem_we}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_col_we", {28'd0, o_col_we}, 32'd0);
        chk("rst_col_index", {29'd0, o_col_index}, 32'd0);
        chk("rst_col_wdata", o_col_wdata, 32'd0);
        chk("rst_tag_we", {31'd0, o_tag_we}, 32'd0);
        chk("rst_tag", {7'd0, o_tag}, 32'd0);
        chk("rst_done", {31'd0, o_refill_done}, 32'd0);
        nrst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            do_refill(tbl[i].addr, tbl[i].dirty, tbl[i].vtag, vd, tbl[i].d,
                      1'b0, gc, gr, gw);
            chk("tbl_cycles", gc, tbl[i].cycles);
            chk("tbl_rd0", gr, tbl[i].rd0);
            chk("tbl_wr0", gw, tbl[i].wr0);
            chk("tbl_tag", {7'd0, tag_val}, {7'd0, tbl[i].tag});
            if (col_idx_q.size() > 0) begin
                chk("tbl_idx", {29'd0, col_idx_q[0]}, {29'd0, tbl[i].idx});
            end else begin
                chk("tbl_idx_missing", 32'd0, 32'd1);
            end
        end

        spur = 1'b1;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("spur_busy", {31'd0, o_busy}, 32'd0);
            chk("spur_req", {31'd0, o_mem_req}, 32'd0);
        end
        spur = 1'b0;
        step();
        chk("spur_no_xfer", wr_addr_q.size() + rd_addr_q.size(), 0);

        clear_log();
        delay          = 0;
        wait_cnt       = 0;
        i_miss_addr    = 32'h0000_3330;
        i_victim_dirty = 1'b0;
        i_miss         = 1'b1;
        step();
        for (int n = 0; n < 50 && !done_seen; n++) begin
            step();
        end
        chk("held_done", {31'd0, done_seen}, 32'd1);
        i_miss_addr = 32'h0000_5550;
        step();
        chk("held_idle", {31'd0, o_busy}, 32'd0);
        step();
        chk("held_restart_busy", {31'd0, o_busy}, 32'd1);
        chk("held_restart_req", {31'd0, o_mem_req}, 32'd1);
        chk("held_restart_addr", o_mem_addr, 32'h0000_5550);
        i_miss = 1'b0;
        done_seen = 1'b0;
        for (int n = 0; n < 50 && !done_seen; n++) begin
            step();
        end
        step();

        clear_log();
        delay          = 0;
        wait_cnt       = 0;
        i_miss_addr    = 32'h0000_4560;
        i_victim_dirty = 1'b0;
        i_miss         = 1'b1;
        step();
        i_miss = 1'b0;
        for (int n = 0; n < 20 && rd_addr_q.size() < 2; n++) begin
            step();
        end
        chk("mid_busy", {31'd0, o_busy}, 32'd1);
        chk("mid_cols", col_we_log.size(), 2);
        #2;
        nrst = 1'b0;
        #1;
        pend      = 1'b0;
        i_mem_ack = 1'b0;
        chk("mrst_busy", {31'd0, o_busy}, 32'd0);
        chk("mrst_req", {31'd0, o_mem_req}, 32'd0);
        chk("mrst_addr", o_mem_addr, 32'd0);
        chk("mrst_col_we", {28'd0, o_col_we}, 32'd0);
        chk("mrst_tag_we", {31'd0, o_tag_we}, 32'd0);
        chk("mrst_done", {31'd0, o_refill_done}, 32'd0);
        repeat (3) step();
        chk("mrst_no_more_cols", col_we_log.size(), 2);
        chk("mrst_no_tag", tag_cnt, 0);
        nrst = 1'b1;
        step();
        do_refill(32'h0000_7778, 1'b0, 25'h0, vd, 0, 1'b0, gc, gr, gw);
        chk("mrst_restart_word0", gr, 32'h0000_7770);

        for (int i = 0; i < 40; i++) begin
            do_refill($urandom, 1'($urandom), TAGW'($urandom),
                      {$urandom, $urandom, $urandom, $urandom},
                      int'($urandom_range(3, 0)), 1'b1, gc, gr, gw);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
